// File: rtl/fifo_flags.sv
// rtl/fifo_flags.sv - synchronous FIFO with occupancy count, status flags and error pulses
module fifo_flags #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic             write_ok;
    logic             read_ok;

    // The extra pointer MSB makes the modular difference span 0..DEPTH.
    assign count        = wr_ptr - rd_ptr;
    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    assign read_ok  = rd_en && !empty;
    assign write_ok = wr_en && (!full || rd_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_ok) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (read_ok) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            overflow  <= wr_en && full && !rd_en;
            underflow <= rd_en && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head is shown only while non-empty so stale storage never leaks out.
            assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
        end else begin : g_registered
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout <= '0;
                end else if (read_ok) begin
                    dout <= mem[rd_ptr[AW-1:0]];
                end
            end
        end
    endgenerate
endmodule
